// File: rtl/ibex_fetch_queue.sv
// Instruction fetch queue with halfword realignment.
// Sits between the instruction memory request logic and the IF-ID register.
// Stores 32-bit fetched words, presents one aligned 16/32-bit instruction per
// handshake, bypasses the input word when empty and flushes in one cycle.
// Optional macro IBEX_FETCH_QUEUE_OCC_EN adds the occupancy_o output.
module ibex_fetch_queue #(
  parameter int unsigned Depth          = 3,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] in_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_rdata_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
`ifdef IBEX_FETCH_QUEUE_OCC_EN
  ,
  output logic [$clog2(Depth+1)-1:0] occupancy_o
`endif
);

  // Entries are compacted, so "occupancy >= Depth-NumOutstanding" is just
  // the valid bit of entry Depth-NumOutstanding-1.
  localparam int unsigned BusyIdx = Depth - NumOutstanding - 1;

  logic [Depth-1:0][31:0] rdata_q, rdata_d, rdata_sh;
  logic [Depth-1:0]       err_q, err_d, err_sh;
  logic [Depth-1:0]       valid_q, valid_d, valid_sh;
  logic [31:0]            pc_q, pc_d;

  logic        h0_valid, h0_err, h1_valid, h1_err;
  logic [31:0] h0_rdata, h1_rdata;
  logic [15:0] instr_hw;
  logic        compressed, valid_raw, err_raw, plus2_raw;
  logic        fire, pop, push, placed;

  // Head view: stored entries first, then the incoming word as bypass.
  assign h0_valid = valid_q[0] | in_valid_i;
  assign h0_rdata = valid_q[0] ? rdata_q[0] : in_rdata_i;
  assign h0_err   = valid_q[0] ? err_q[0]   : in_err_i;
  assign h1_valid = valid_q[1] | (valid_q[0] & in_valid_i);
  assign h1_rdata = valid_q[1] ? rdata_q[1] : in_rdata_i;
  assign h1_err   = valid_q[1] ? err_q[1]   : in_err_i;

  assign instr_hw   = pc_q[1] ? h0_rdata[31:16] : h0_rdata[15:0];
  assign compressed = (instr_hw[1:0] != 2'b11);

  // Realign the head words into one instruction according to pc[1].
  always_comb begin
    valid_raw   = h0_valid;
    err_raw     = h0_err;
    plus2_raw   = 1'b0;
    out_rdata_o = h0_rdata;
    if (!pc_q[1]) begin
      if (compressed) out_rdata_o = {16'h0, h0_rdata[15:0]};
    end else if (compressed) begin
      out_rdata_o = {16'h0, h0_rdata[31:16]};
    end else begin
      // A faulted first half is presented alone so the fault is not stalled.
      valid_raw   = h0_valid & (h1_valid | h0_err);
      out_rdata_o = {(h1_valid ? h1_rdata[15:0] : 16'h0), h0_rdata[31:16]};
      err_raw     = h0_err | (h1_valid & h1_err);
      plus2_raw   = h1_valid & h1_err & ~h0_err;
    end
  end

  assign out_valid_o     = valid_raw & ~clear_i;
  assign out_err_o       = out_valid_o & err_raw;
  assign out_err_plus2_o = out_valid_o & plus2_raw;
  assign out_addr_o      = pc_q;
  assign busy_o          = valid_q[BusyIdx];

  assign fire = out_valid_o & out_ready_i;
  // Pop when the consumed instruction reaches the head word's upper half.
  assign pop  = fire & (pc_q[1] | ~compressed);
  // A popped bypass word (queue empty) is consumed, never stored.
  assign push = in_valid_i & ~clear_i & ~(pop & ~valid_q[0]);

  // Shift-down view of the entries used when popping.
  for (genvar g = 0; g < Depth; g++) begin : g_shift
    if (g < Depth - 1) begin : g_mid
      assign rdata_sh[g] = rdata_q[g+1];
      assign err_sh[g]   = err_q[g+1];
      assign valid_sh[g] = valid_q[g+1];
    end else begin : g_top
      assign rdata_sh[g] = rdata_q[g];
      assign err_sh[g]   = err_q[g];
      assign valid_sh[g] = 1'b0;
    end
  end

  // Next entry state: optional shift, then write input into lowest free slot.
  always_comb begin
    rdata_d = pop ? rdata_sh : rdata_q;
    err_d   = pop ? err_sh   : err_q;
    valid_d = pop ? valid_sh : valid_q;
    placed  = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (push && !placed && !valid_d[i]) begin
        rdata_d[i] = in_rdata_i;
        err_d[i]   = in_err_i;
        valid_d[i] = 1'b1;
        placed     = 1'b1;
      end
    end
    if (clear_i) valid_d = '0;
  end

  // Next PC: reload on flush, otherwise advance by the consumed size.
  always_comb begin
    pc_d = pc_q;
    if (clear_i)   pc_d = {in_addr_i[31:1], 1'b0};
    else if (fire) pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
  end

  // Entry and PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= '0;
      valid_q <= '0;
      pc_q    <= '0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IBEX_FETCH_QUEUE_OCC_EN
  localparam int unsigned OccW = $clog2(Depth + 1);
  logic [OccW-1:0] occ_d, occ_q;

  // Population count of the next valid vector.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < Depth; i++) occ_d = occ_d + OccW'(valid_d[i]);
  end

  // Registered occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign occupancy_o = occ_q;
`endif

  logic unused_sig;
  assign unused_sig = in_addr_i[0] ^ (^h1_rdata[31:16]);

`ifndef SYNTHESIS
  // The queue has no input ready; the requester must honour busy_o.
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && valid_q[Depth-1] && !pop));
`endif

endmodule

// File: tb/tb_ibex_fetch_queue.sv
// Bench for ibex_fetch_queue: directed vector table plus random traffic
// checked against a word-queue reference model.
module tb_ibex_fetch_queue;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NOUT  = 2;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        clear_i = 1'b0, in_valid_i = 1'b0, in_err_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] in_addr_i = '0, in_rdata_i = '0;
  logic        busy_o, out_valid_o, out_err_o, out_err_plus2_o;
  logic [31:0] out_addr_o, out_rdata_o;
`ifdef IBEX_FETCH_QUEUE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;
`endif

  ibex_fetch_queue #(.Depth(DEPTH), .NumOutstanding(NOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .in_addr_i(in_addr_i),
    .in_valid_i(in_valid_i), .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_rdata_o(out_rdata_o), .out_err_o(out_err_o),
    .out_err_plus2_o(out_err_plus2_o)
`ifdef IBEX_FETCH_QUEUE_OCC_EN
    , .occupancy_o(occupancy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
  endtask

  typedef struct {
    logic clr; logic [31:0] addr; logic iv; logic [31:0] d; logic e; logic rdy;
    logic ev; logic [31:0] ed; logic [31:0] ea; logic ee; logic ep; logic eb; int eo;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic clr, logic [31:0] addr, logic iv, logic [31:0] d, logic e,
                              logic rdy, logic ev, logic [31:0] ed, logic [31:0] ea,
                              logic ee, logic ep, logic eb, int eo);
    vec_t v;
    v.clr = clr; v.addr = addr; v.iv = iv; v.d = d; v.e = e; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ea = ea; v.ee = ee; v.ep = ep; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  task automatic drive(input logic clr, input logic [31:0] addr, input logic iv,
                       input logic [31:0] d, input logic e, input logic rdy);
    @(posedge clk_i); #1;
    clear_i = clr; in_addr_i = addr; in_valid_i = iv; in_rdata_i = d;
    in_err_i = e; out_ready_i = rdy;
  endtask

  // Reference model: list of stored words plus the PC.
  typedef struct { logic [31:0] d; logic e; } word_t;
  word_t       wq[$];
  logic [31:0] mpc;

  initial begin
    word_t avail[$];
    word_t w;
    logic ev, ee, ep, comp, upper;
    logic [31:0] ed;
    logic [15:0] hw;
    logic clr, iv, e, rdy;
    logic [31:0] addr, d;

    // Bypass
    tbl.push_back(mk(1, 32'h80,       0, 0,            0, 0, 0, 0,            32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h00A00093, 0, 1, 1, 32'h00A00093, 32'h80,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 0, 0,            32'h84,  0, 0, 0, 0));
    // Compressed pair
    tbl.push_back(mk(1, 32'h100,      0, 0,            0, 0, 0, 0,            32'h84,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h45054501, 0, 0, 1, 32'h00004501, 32'h100, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 1, 32'h00004501, 32'h100, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 1, 32'h00004505, 32'h102, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 0, 0,            32'h104, 0, 0, 0, 0));
    // Spanning
    tbl.push_back(mk(1, 32'h102,      0, 0,            0, 0, 0, 0,            32'h104, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h00934501, 0, 1, 0, 0,            32'h102, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 0, 0,            32'h102, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            1, 32'hFFFF00A0, 0, 1, 1, 32'h00A00093, 32'h102, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 0, 0,            32'h106, 0, 0, 1, 1));
    // Error in upper half only
    tbl.push_back(mk(1, 32'h102,      0, 0,            0, 0, 0, 0,            32'h106, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            1, 32'h00934501, 0, 1, 0, 0,            32'h102, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'hFFFF00A0, 1, 0, 1, 32'h00A00093, 32'h102, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0,            0, 0,            0, 1, 1, 32'h00A00093, 32'h102, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 1, 32'h0000FFFF, 32'h106, 1, 0, 1, 1));
    // Error in first word only: presented before the second word arrives
    tbl.push_back(mk(1, 32'h102,      0, 0,            0, 0, 0, 0,            32'h106, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            1, 32'h00934501, 1, 0, 1, 32'h00000093, 32'h102, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 1, 32'h00000093, 32'h102, 1, 0, 1, 1));
    // Busy / fill to Depth
    tbl.push_back(mk(1, 32'h0,        0, 0,            0, 0, 0, 0,            32'h102, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            1, 32'h11111111, 0, 0, 1, 32'h00001111, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h22222223, 0, 0, 1, 32'h00001111, 32'h0,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0,            1, 32'h33333333, 0, 0, 1, 32'h00001111, 32'h0,   0, 0, 1, 2));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 1, 32'h00001111, 32'h0,   0, 0, 1, 3));
    // Flush of a full queue, with a discarded input word and ready high
    tbl.push_back(mk(1, 32'h2003,     1, 32'h44444444, 0, 1, 0, 0,            32'h0,   0, 0, 1, 3));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 0, 0,            32'h2002, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h55550001, 0, 1, 1, 32'h00005555, 32'h2002, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 0, 0,            32'h2004, 0, 0, 0, 0));
    // PC wrap
    tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0,            0, 0, 0, 0,            32'h2004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            1, 32'h00A00093, 0, 1, 1, 32'h00A00093, 32'hFFFFFFFC, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,            0, 0,            0, 0, 0, 0,            32'h0,   0, 0, 0, 0));

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 0, 32'(out_valid_o), 0);
    chk("rst_busy",  0, 32'(busy_o), 0);
    chk("rst_err",   0, 32'(out_err_o), 0);
    chk("rst_plus2", 0, 32'(out_err_plus2_o), 0);
    chk("rst_addr",  0, out_addr_o, 0);
`ifdef IBEX_FETCH_QUEUE_OCC_EN
    chk("rst_occ",   0, 32'(occupancy_o), 0);
`endif
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].addr, tbl[i].iv, tbl[i].d, tbl[i].e, tbl[i].rdy);
      @(negedge clk_i);
      chk("valid", i, 32'(out_valid_o), 32'(tbl[i].ev));
      chk("addr",  i, out_addr_o, tbl[i].ea);
      chk("busy",  i, 32'(busy_o), 32'(tbl[i].eb));
      if (tbl[i].ev) begin
        chk("rdata", i, out_rdata_o, tbl[i].ed);
        chk("err",   i, 32'(out_err_o), 32'(tbl[i].ee));
        chk("plus2", i, 32'(out_err_plus2_o), 32'(tbl[i].ep));
      end
`ifdef IBEX_FETCH_QUEUE_OCC_EN
      chk("occ",   i, 32'(occupancy_o), 32'(tbl[i].eo));
`endif
    end

    // Random traffic against the model; the table leaves the queue empty at PC 0.
    wq = {};
    mpc = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      clr  = (c == 0) || ($urandom_range(39, 0) == 0);
      addr = $urandom;
      iv   = (wq.size() < DEPTH) && $urandom_range(1, 0);
      d    = $urandom;
      if ($urandom_range(1, 0) == 1) d[1:0]   = 2'b11;
      if ($urandom_range(1, 0) == 1) d[17:16] = 2'b11;
      e    = ($urandom_range(7, 0) == 0);
      rdy  = ($urandom_range(9, 0) < 7);
      drive(clr, addr, iv, d, e, rdy);
      @(negedge clk_i);

      avail = wq;
      if (iv) begin w.d = d; w.e = e; avail.push_back(w); end
      ev = 0; ed = 0; ee = 0; ep = 0; comp = 0; upper = 0;
      if (!clr && avail.size() > 0) begin
        hw   = mpc[1] ? avail[0].d[31:16] : avail[0].d[15:0];
        comp = (hw[1:0] != 2'b11);
        ee   = avail[0].e;
        if (comp) begin
          ev = 1; ed = {16'h0, hw}; upper = mpc[1];
        end else if (!mpc[1]) begin
          ev = 1; ed = avail[0].d; upper = 1;
        end else begin
          upper = 1;
          if (avail.size() > 1) begin
            ev = 1; ed = {avail[1].d[15:0], hw};
            ee = avail[0].e | avail[1].e;
            ep = avail[1].e & ~avail[0].e;
          end else if (avail[0].e) begin
            ev = 1; ed = {16'h0, hw};
          end
        end
      end

      chk("r_valid", c, 32'(out_valid_o), 32'(ev));
      chk("r_addr",  c, out_addr_o, mpc);
      chk("r_busy",  c, 32'(busy_o), 32'(wq.size() >= DEPTH - NOUT));
      if (ev) begin
        chk("r_rdata", c, out_rdata_o, ed);
        chk("r_err",   c, 32'(out_err_o), 32'(ee));
        chk("r_plus2", c, 32'(out_err_plus2_o), 32'(ep));
      end
`ifdef IBEX_FETCH_QUEUE_OCC_EN
      chk("r_occ",   c, 32'(occupancy_o), 32'(wq.size()));
`endif

      if (clr) begin
        wq = {};
        mpc = {addr[31:1], 1'b0};
      end else begin
        if (ev && rdy) begin
          mpc = mpc + (comp ? 32'd2 : 32'd4);
          if (upper) void'(avail.pop_front());
        end
        wq = avail;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ibex_fetch_queue.md
Name: ibex_fetch_queue

Overview:
- Parametrised-depth instruction fetch queue with halfword realignment. It sits between the instruction memory request logic and the IF-ID pipeline register.
- Accepts 32-bit fetched words with a bus-error flag and presents one aligned 16- or 32-bit instruction per handshake.
- Supports instructions spanning word boundaries, error attribution to either half, zero-latency bypass when empty, and single-cycle flush on branch.
- Generalises a fixed 3-entry queue to configurable depth and configurable outstanding-request headroom.

Parameters:
- Depth, 3, number of 32-bit word entries; must be >= 2 and > NumOutstanding.
- NumOutstanding, 2, maximum bus requests the requester may have in flight; used only to derive busy_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  flush all entries and load a new PC from in_addr_i
- in_addr_i  in  32  new PC; sampled only when clear_i=1
- in_valid_i  in  1  fetched word valid (bus rvalid); no ready, the queue must never overflow
- in_rdata_i  in  32  fetched word
- in_err_i  in  1  bus/PMP error for this word
- busy_o  out  1  occupied entries >= Depth-NumOutstanding; requester must not issue a new request while high
- out_valid_o  out  1  aligned instruction available
- out_ready_i  in  1  consumer accepts instruction
- out_addr_o  out  32  PC of presented instruction
- out_rdata_o  out  32  instruction; compressed instructions are zero-extended to 32 bits
- out_err_o  out  1  instruction fetch faulted
- out_err_plus2_o  out  1  fault lies only in the upper halfword of an unaligned 32-bit instruction

Behaviour:
- Reset values:
  - all entry valid bits 0; PC register 0
  - out_valid_o=0, busy_o=0, out_err_o=0, out_err_plus2_o=0, out_addr_o=0
- Storage:
  - entries are compacted; entry 0 is the head
  - an incoming word is written to the lowest free entry
  - a simultaneous pop shifts all entries down one and writes the incoming word at (occupancy-1)
- Head view:
  - H0 = entry0 if valid, else input word if in_valid_i (bypass, 0-cycle latency)
  - H1 = entry1 if valid, else input word if entry0 is valid and in_valid_i
- Compressed detect: instruction bits [1:0] != 2'b11, taken from the selected halfword.
- Aligned PC (pc[1]=0):
  - out_valid_o = H0 present
  - compressed: rdata = {16'h0, H0[15:0]}
  - uncompressed: rdata = H0
  - err = H0.err; err_plus2 = 0
- Unaligned PC (pc[1]=1):
  - compressed: valid = H0 present; rdata = {16'h0, H0[31:16]}; err = H0.err
  - uncompressed: valid = (H0 and H1 present) OR (H0 present and H0.err)
  - uncompressed: rdata = {H1[15:0], H0[31:16]}; err = H0.err | H1.err; err_plus2 = H1.err & ~H0.err
  - when H1 is absent and H0 has faulted, the upper 16 bits of rdata are 0
- Handshake (out_valid_o & out_ready_i):
  - PC += 2 if compressed, else += 4 (32-bit wrap at 0xFFFF_FFFC)
  - head word is popped when the consumed instruction ends in or beyond its upper halfword: aligned uncompressed, or any unaligned
  - aligned compressed: no pop
  - if the consumed word came from bypass, it is not stored; only a remaining unconsumed halfword is stored
- Unaligned 32-bit instruction spanning two entries: pop entry0 only; entry1's upper halfword becomes the next instruction at pc+4 (pc[1]=1).
- clear_i:
  - same cycle: out_valid_o forced 0; the in_valid_i word is discarded
  - next cycle: all valid bits 0; PC = {in_addr_i[31:1], 1'b0}
  - clear_i has priority over push and pop; an out_ready_i in the same cycle has no effect
- out_addr_o = PC register (combinational, no extra latency).
- Full with in_valid_i and no pop is an overflow: the word is dropped and a simulation assertion fires.
- Outputs stay stable while out_valid_o=1 and out_ready_i=0, unless clear_i is asserted.

Optional Feature:
- Macro IBEX_FETCH_QUEUE_OCC_EN.
- Defined: adds output port occupancy_o, width $clog2(Depth+1), equal to the registered count of valid entries; reset value 0; drops to 0 the cycle after clear_i.
- Undefined: port absent; no counter logic; all other behaviour unchanged.

Test Plan:
- Bypass:
  - stimulus: clear_i with in_addr_i=0x80; next cycle, empty queue, in_valid_i with 0x00A00093, out_ready_i=1
  - required: same cycle out_valid_o=1, out_rdata_o=0x00A00093, out_addr_o=0x80; next out_addr_o=0x84
- Compressed pair:
  - stimulus: word 0x4505_4501 stored, PC 0x100, ready held high
  - required: 0x00004501 @0x100, then 0x00004505 @0x102, then pop, occupancy 0
- Spanning:
  - stimulus: PC 0x102; words 0x0093_4501 then 0xXXXX_00A0; first word arrives alone
  - required: out_valid_o=0 until second word; then out_rdata_o=0x00A00093, entry0 popped, next PC 0x106
- Error plus2:
  - stimulus: same spanning case with in_err_i=1 on second word only
  - required: out_err_o=1, out_err_plus2_o=1
  - variant: err on first word only gives out_valid_o=1 before the second word arrives, out_err_o=1, out_err_plus2_o=0
- Busy/full:
  - stimulus: Depth=3, NumOutstanding=2, out_ready_i=0, push one word
  - required: busy_o=1
  - further: fill to 3 entries with no overflow assertion; a 4th push fires the assertion
- Flush:
  - stimulus: 3 entries stored, assert clear_i with in_addr_i=0x2002 and out_ready_i=1
  - required: out_valid_o=0 that cycle; next cycle queue empty, out_addr_o=0x2002, and occupancy_o=0 when IBEX_FETCH_QUEUE_OCC_EN is defined
